// File: rtl/halut_decoder_unit.sv
// halut_decoder_unit: looks up one LUT entry per 4-bit code and accumulates C of them into one row result.
// Latency: result_valid_o is visible 2 cycles after the last code of a row is accepted; throughput 1 code/cycle.
// Backpressure: only a row's last code is stalled (code_ready_o low) while an undrained result is pending.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   lut_we_i/lut_waddr_i/lut_wdata_i   LUT write port, address c*K+k, read-first against same-cycle lookups
//   code_valid_i/code_ready_o/code_i   code stream, codebook index implied by an internal counter
//   result_valid_o/result_ready_i      row result handshake, result_o held while stalled
//   busy_o                             row partially received or lookup in flight
//
// Optional build macro HALUT_DECODER_SATURATE_EN: saturating accumulation instead of wrap-around.
module halut_decoder_unit #(
    parameter int C             = 32,
    parameter int K             = 16,
    parameter int DataTypeWidth = 16,
    parameter int AccWidth      = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lut_we_i,
    input  logic [$clog2(C*K)-1:0]      lut_waddr_i,
    input  logic [DataTypeWidth-1:0]    lut_wdata_i,
    input  logic                        code_valid_i,
    output logic                        code_ready_o,
    input  logic [$clog2(K)-1:0]        code_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [AccWidth-1:0]         result_o,
    output logic                        busy_o
);

    localparam int CW = $clog2(C);
    localparam int AW = $clog2(C*K);

    // LUT storage, never reset
    logic [DataTypeWidth-1:0] lut_q [C*K];
    logic signed [DataTypeWidth-1:0] rd_q;

    // control / datapath state
    logic [CW-1:0]       c_cnt_q, c_cnt_d;
    logic                s0_vld_q, s0_vld_d;
    logic                s0_first_q, s0_first_d;
    logic                s0_last_q, s0_last_d;
    logic [AccWidth-1:0] acc_q, acc_d;
    logic [AccWidth-1:0] result_q, result_d;
    logic                result_vld_q, result_vld_d;

    logic                code_fire;
    logic                c_is_last;
    logic [AW-1:0]       raddr;
    logic [AccWidth-1:0] entry_ext;
    logic [AccWidth-1:0] base;
    logic [AccWidth-1:0] acc_next;

    assign c_is_last    = (c_cnt_q == CW'(C - 1));
    // Only the last code of a row can create a second outstanding result, so only it is stalled.
    assign code_ready_o = !(c_is_last && result_vld_q && !result_ready_i);
    assign code_fire    = code_valid_i && code_ready_o;
    // K is a power of two, so c*K+k is a plain concatenation.
    assign raddr        = {c_cnt_q, code_i};

    assign entry_ext    = AccWidth'(rd_q);
    assign base         = s0_first_q ? '0 : acc_q;

`ifdef HALUT_DECODER_SATURATE_EN
    logic [AccWidth:0] sum_w;
    assign sum_w = {base[AccWidth-1], base} + {entry_ext[AccWidth-1], entry_ext};
    always_comb begin
        acc_next = sum_w[AccWidth-1:0];
        // Sign of the wide sum differing from the narrow MSB means the narrow result overflowed.
        if (sum_w[AccWidth] != sum_w[AccWidth-1]) begin
            acc_next = sum_w[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                       : {1'b0, {(AccWidth-1){1'b1}}};
        end
    end
`else
    assign acc_next = base + entry_ext;
`endif

    always_comb begin
        c_cnt_d      = c_cnt_q;
        s0_vld_d     = code_fire;
        s0_first_d   = (c_cnt_q == '0);
        s0_last_d    = c_is_last;
        acc_d        = acc_q;
        result_d     = result_q;
        result_vld_d = result_vld_q;

        if (code_fire) begin
            c_cnt_d = c_is_last ? '0 : c_cnt_q + CW'(1);
        end

        if (s0_vld_q) begin
            acc_d = acc_next;
        end

        // A new result loading wins over the drain of the old one.
        if (s0_vld_q && s0_last_q) begin
            result_d     = acc_next;
            result_vld_d = 1'b1;
        end else if (result_vld_q && result_ready_i) begin
            result_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_cnt_q      <= '0;
            s0_vld_q     <= 1'b0;
            s0_first_q   <= 1'b0;
            s0_last_q    <= 1'b0;
            acc_q        <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
        end else begin
            c_cnt_q      <= c_cnt_d;
            s0_vld_q     <= s0_vld_d;
            s0_first_q   <= s0_first_d;
            s0_last_q    <= s0_last_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
        end
    end

    // Nonblocking update gives read-first behaviour on a same-cycle write/lookup collision.
    always_ff @(posedge clk_i) begin
        if (lut_we_i) begin
            lut_q[lut_waddr_i] <= lut_wdata_i;
        end
        if (code_fire) begin
            rd_q <= lut_q[raddr];
        end
    end

    assign result_valid_o = result_vld_q;
    assign result_o       = result_q;
    assign busy_o         = (c_cnt_q != '0) || s0_vld_q;

endmodule

// File: tb/tb_halut_decoder_unit.sv
module tb_halut_decoder_unit;

    localparam int C  = 4;
    localparam int K  = 16;
    localparam int DW = 16;
    localparam int NA = C * K;
`ifdef HALUT_DECODER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [5:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        cv = 1'b0;
    logic [3:0]  code = '0;
    logic        rr = 1'b0;
    logic        cr, cr16, rv, rv16, busy, busy16;
    logic [31:0] res;
    logic [15:0] res16;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] lut_sh [NA];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    halut_decoder_unit #(.C(C), .K(K), .DataTypeWidth(DW), .AccWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .lut_we_i(we), .lut_waddr_i(waddr), .lut_wdata_i(wdata),
        .code_valid_i(cv), .code_ready_o(cr), .code_i(code),
        .result_valid_o(rv), .result_ready_i(rr), .result_o(res), .busy_o(busy)
    );

    halut_decoder_unit #(.C(C), .K(K), .DataTypeWidth(DW), .AccWidth(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .lut_we_i(we), .lut_waddr_i(waddr), .lut_wdata_i(wdata),
        .code_valid_i(cv), .code_ready_o(cr16), .code_i(code),
        .result_valid_o(rv16), .result_ready_i(rr), .result_o(res16), .busy_o(busy16)
    );

    // Reference: sum of looked-up entries as plain integers, clamped per step when saturating.
    function automatic longint model_row(input int codes[C], input int aw, input bit sat);
        longint acc, e, hi, lo;
        hi  = (longint'(1) <<< (aw - 1)) - 1;
        lo  = -hi - 1;
        acc = 0;
        for (int c = 0; c < C; c++) begin
            e   = longint'(lut_sh[c*K + codes[c]]);
            acc = (c == 0) ? e : acc + e;
            if (sat) begin
                if (acc > hi) acc = hi;
                else if (acc < lo) acc = lo;
            end
        end
        return acc;
    endfunction

    task automatic write_lut(input int a, input int d);
        we = 1'b1; waddr = 6'(a); wdata = 16'(d);
        @(posedge clk); #1;
        we = 1'b0;
        lut_sh[a] = 16'(d);
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < NA; a++) write_lut(a, a);
    endtask

    task automatic fill_const(input int d);
        for (int a = 0; a < NA; a++) write_lut(a, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_code(input int cd, output int hs);
        bit done;
        done = 1'b0; hs = -1;
        cv = 1'b1; code = cd[3:0];
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (cr) begin done = 1'b1; hs = cyc; end
            @(posedge clk); #1;
        end
        cv = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL send_code_timeout code=%0d: ready stayed low, required accept within 20 cycles", cd);
        end
    endtask

    task automatic send_row(input int codes[C], output int hs);
        for (int c = 0; c < C; c++) send_code(codes[c], hs);
    endtask

    task automatic wait_result(output logic [31:0] r, output logic [15:0] r2, output int rc, output bit ok);
        ok = 1'b0; rc = -1; r = '0; r2 = '0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (rv) begin ok = 1'b1; r = res; r2 = res16; rc = cyc; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rv !== 1'b0)   begin n_errors++; $display("FAIL reset_valid got=%b exp=0", rv); end
        n_checks++; if (res !== 32'd0) begin n_errors++; $display("FAIL reset_result got=%h exp=0", res); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (cr !== 1'b1)   begin n_errors++; $display("FAIL reset_ready got=%b exp=1", cr); end
        rst = 1'b0;
        rr = 1'b1;
    endtask

    task automatic test_basic_row();
        int row[C]; int hs; int rc; bit ok; logic [31:0] r; logic [15:0] r2;
        fill_ramp();
        row = '{3, 5, 7, 9};
        send_code(row[0], hs);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int c = 1; c < C; c++) send_code(row[c], hs);
        wait_result(r, r2, rc, ok);
        n_checks++; if (ok !== 1'b1)     begin n_errors++; $display("FAIL basic_timeout got=%b exp=1", ok); end
        n_checks++; if (r !== 32'd120)   begin n_errors++; $display("FAIL basic_sum got=%0d exp=120", r); end
        n_checks++; if (r2 !== 16'd120)  begin n_errors++; $display("FAIL basic_sum16 got=%0d exp=120", r2); end
        n_checks++; if (rc - hs !== 2)   begin n_errors++; $display("FAIL basic_latency got=%0d exp=2", rc - hs); end
        n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_sign_ext();
        int row[C]; int hs; int rc; bit ok; logic [31:0] r; logic [15:0] r2;
        fill_const(16'hFFFF);
        row = '{0, 0, 0, 0};
        send_row(row, hs);
        wait_result(r, r2, rc, ok);
        n_checks++; if (r !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL signext_sum got=%h exp=fffffffc", r); end
        n_checks++; if (r2 !== 16'hFFFC)    begin n_errors++; $display("FAIL signext_sum16 got=%h exp=fffc", r2); end
    endtask

    task automatic test_backpressure();
        int row[C]; int hs; int h;
        fill_ramp();
        rr = 1'b0;
        row = '{3, 5, 7, 9};
        send_row(row, hs);
        send_code(1, h); send_code(2, h); send_code(3, h);
        cv = 1'b1; code = 4'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (cr !== 1'b0)     begin n_errors++; $display("FAIL bp_ready_low got=%b exp=0", cr); end
            n_checks++; if (rv !== 1'b1)     begin n_errors++; $display("FAIL bp_valid_held got=%b exp=1", rv); end
            n_checks++; if (res !== 32'd120) begin n_errors++; $display("FAIL bp_result_held got=%0d exp=120", res); end
            @(posedge clk); #1;
        end
        rr = 1'b1;
        @(negedge clk);
        n_checks++; if (cr !== 1'b1) begin n_errors++; $display("FAIL bp_accept got=%b exp=1", cr); end
        hs = cyc;
        @(posedge clk); #1;
        cv = 1'b0;
        @(negedge clk);
        n_checks++; if (rv !== 1'b0) begin n_errors++; $display("FAIL bp_drained got=%b exp=0", rv); end
        @(negedge clk);
        n_checks++; if (rv !== 1'b1)       begin n_errors++; $display("FAIL bp_row2_valid got=%b exp=1", rv); end
        n_checks++; if (res !== 32'd106)   begin n_errors++; $display("FAIL bp_row2_sum got=%0d exp=106", res); end
        n_checks++; if (res16 !== 16'd106) begin n_errors++; $display("FAIL bp_row2_sum16 got=%0d exp=106", res16); end
        n_checks++; if (cyc - hs !== 2)    begin n_errors++; $display("FAIL bp_row2_latency got=%0d exp=2", cyc - hs); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_row();
        int row[C]; int hs; int rc; bit ok; logic [31:0] r; logic [15:0] r2;
        send_code(3, hs); send_code(5, hs);
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (rv !== 1'b0) begin n_errors++; $display("FAIL midrst_no_result got=%b exp=0", rv); end
            @(posedge clk); #1;
        end
        row = '{3, 5, 7, 9};
        send_row(row, hs);
        wait_result(r, r2, rc, ok);
        n_checks++; if (r !== 32'd120) begin n_errors++; $display("FAIL midrst_sum got=%0d exp=120", r); end
    endtask

    task automatic test_saturation();
        int row[C]; int hs; int rc; bit ok; logic [31:0] r; logic [15:0] r2; logic [15:0] e16;
        fill_const(16'h7FFF);
        for (int c = 0; c < C; c++) row[c] = $urandom_range(0, K - 1);
        e16 = SAT ? 16'h7FFF : 16'hFFFC;
        send_row(row, hs);
        wait_result(r, r2, rc, ok);
        n_checks++; if (r !== 32'h0001FFFC) begin n_errors++; $display("FAIL sat_sum32 got=%h exp=0001fffc", r); end
        n_checks++; if (r2 !== e16)         begin n_errors++; $display("FAIL sat_sum16 got=%h exp=%h", r2, e16); end
    endtask

    task automatic test_read_during_write();
        int row[C]; int hs; int h; int rc; bit ok; logic [31:0] r; logic [15:0] r2;
        fill_ramp();
        write_lut(0, 10);
        cv = 1'b1; code = 4'd0;
        we = 1'b1; waddr = 6'd0; wdata = 16'd99;
        @(negedge clk);
        n_checks++; if (cr !== 1'b1) begin n_errors++; $display("FAIL rdw_accept got=%b exp=1", cr); end
        @(posedge clk); #1;
        cv = 1'b0; we = 1'b0; lut_sh[0] = 16'sd99;
        send_code(5, h); send_code(7, h); send_code(9, h);
        wait_result(r, r2, rc, ok);
        n_checks++; if (r !== 32'd127) begin n_errors++; $display("FAIL rdw_old_data got=%0d exp=127", r); end
        row = '{0, 5, 7, 9};
        send_row(row, hs);
        wait_result(r, r2, rc, ok);
        n_checks++; if (r !== 32'd216) begin n_errors++; $display("FAIL rdw_new_data got=%0d exp=216", r); end
    endtask

    task automatic test_random_rows();
        localparam int N = 12;
        logic [31:0] exp32 [$];
        logic [15:0] exp16 [$];
        int got;
        for (int a = 0; a < NA; a++) write_lut(a, $urandom_range(0, 65535));
        got = 0;
        fork
            begin
                int row[C]; int h;
                for (int rw = 0; rw < N; rw++) begin
                    for (int c = 0; c < C; c++) row[c] = $urandom_range(0, K - 1);
                    exp32.push_back(32'(model_row(row, 32, SAT)));
                    exp16.push_back(16'(model_row(row, 16, SAT)));
                    for (int c = 0; c < C; c++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send_code(row[c], h);
                    end
                end
            end
            begin
                bit held_v; logic [31:0] held;
                held_v = 1'b0; held = '0;
                for (int n = 0; n < 3000 && got < N; n++) begin
                    @(posedge clk); #1;
                    rr = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (held_v && rv) begin
                        n_checks++;
                        if (res !== held) begin n_errors++; $display("FAIL rnd_stable got=%h exp=%h", res, held); end
                    end
                    held_v = rv && !rr; held = res;
                    if (rv && rr) begin
                        n_checks++;
                        if (exp32.size() == 0) begin
                            n_errors++; $display("FAIL rnd_extra got=%h exp=none", res);
                        end else begin
                            if (res !== exp32[0]) begin n_errors++; $display("FAIL rnd_sum32 row=%0d got=%h exp=%h", got, res, exp32[0]); end
                            n_checks++;
                            if (res16 !== exp16[0]) begin n_errors++; $display("FAIL rnd_sum16 row=%0d got=%h exp=%h", got, res16, exp16[0]); end
                            void'(exp32.pop_front()); void'(exp16.pop_front());
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++; if (got !== N) begin n_errors++; $display("FAIL rnd_count got=%0d exp=%0d", got, N); end
        @(posedge clk); #1;
        rr = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_row();
        test_sign_ext();
        test_backpressure();
        test_reset_mid_row();
        test_saturation();
        test_read_during_write();
        test_random_rows();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/halut_decoder_unit.md
Name: halut_decoder_unit

Overview:
- Decode stage of the HALUT matmul datapath; one instance per output column, replicated DecoderUnits times by the decoder array.
- Consumes the encoder's stream of 4-bit prototype codes, one per codebook c = 0..C-1 of an input row.
- Looks up each code in a locally written LUT of C*K signed entries and accumulates the C looked-up values into one output element per row.
- Presents each row result on a ready/valid output register.

Parameters:
- C, 32 (halut_pkg::C): codebooks per row; must be >= 2.
- K, 16 (halut_pkg::K): prototypes per codebook; power of two.
- DataTypeWidth, 16 (halut_pkg::DataTypeWidth): LUT entry width, signed two's complement.
- AccWidth, 32: accumulator and result width; must be >= DataTypeWidth.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- lut_we_i  in  1  LUT write enable.
- lut_waddr_i  in  $clog2(C*K)  LUT write address, c*K+k.
- lut_wdata_i  in  DataTypeWidth  LUT write data.
- code_valid_i  in  1  code valid.
- code_ready_o  out  1  code ready.
- code_i  in  $clog2(K)  prototype index for the current codebook.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result ready.
- result_o  out  AccWidth  accumulated row result.
- busy_o  out  1  high while a row is partially received or a lookup is in flight.

Behaviour:
- Reset values:
  - code_ready_o follows its combinational rule.
  - result_valid_o=0, result_o=0, busy_o=0.
  - Codebook counter c_cnt=0; pipeline valid=0; accumulator=0.
  - LUT contents are not reset.
- Code handshake:
  - A code is accepted when code_valid_i && code_ready_o.
  - Its codebook index is c_cnt. c_cnt increments per accepted code and wraps C-1 -> 0.
  - No explicit last signal: the code accepted at c_cnt==C-1 ends the row.
- Stage 0 (acceptance cycle t):
  - LUT is read at address c_cnt*K+code_i as a synchronous 1-cycle read.
  - The stage registers the valid, first (c_cnt==0) and last (c_cnt==C-1) flags.
- Stage 1 (cycle t+1):
  - The entry is sign-extended to AccWidth.
  - If first: acc <= entry. Otherwise: acc <= acc + entry, modulo 2^AccWidth.
  - If last: result_o <= acc_next and result_valid_o <= 1 at the same edge.
- Latency and throughput:
  - result_valid_o is visible 2 cycles after the handshake of the last code.
  - Throughput is 1 code per cycle; back-to-back rows incur no bubble.
- Output handshake:
  - result_valid_o clears on result_valid_o && result_ready_i unless a new result loads at the same edge. In that case it stays 1 with the new value.
  - result_o is held stable while valid && !ready.
- Backpressure: code_ready_o = !(c_cnt==C-1 && result_valid_o && !result_ready_i).
  - A row's last code is never accepted while an unconsumed result exists that is not draining this cycle.
  - Non-last codes are always accepted.
  - C >= 2 guarantees at most one result in flight.
- LUT write/read collision:
  - Writes are allowed in any cycle.
  - A same-cycle read of the written address returns the old data (read-first).
- busy_o = (c_cnt != 0) || stage-0 valid.
- Reset mid-row: the partial row is discarded. The next accepted code is treated as c=0 and no stale accumulator value leaks.

Optional Feature:
- Macro: HALUT_DECODER_SATURATE_EN.
- Defined: stage-1 addition saturates to the signed AccWidth range. Saturate to 2^(AccWidth-1)-1 on positive overflow and to -2^(AccWidth-1) on negative overflow.
- Undefined: addition wraps modulo 2^AccWidth.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic row: C=4, LUT[a]=a for all a; codes 3,5,7,9 back-to-back -> result_o=120 (3+21+39+57), result_valid_o rises exactly 2 cycles after the 4th handshake.
- Sign extension: C=4, all LUT entries 16'hFFFF; codes 0,0,0,0 -> result_o=32'hFFFFFFFC.
- Backpressure: C=4, result_ready_i=0; stream two rows continuously -> row 1 result held stable; code_ready_o low while the 4th code of row 2 is presented; raise result_ready_i -> row 1 consumed, row 2 last code accepted that cycle, row 2 result valid 2 cycles later with the correct sum.
- Reset mid-row: C=4, accept 2 codes, pulse rst_i -> busy_o=0, no result; next full row 3,5,7,9 -> 120.
- Saturation: C=4, AccWidth=16, all LUT entries 16'h7FFF, four codes -> 16'hFFFC without macro; 16'h7FFF with HALUT_DECODER_SATURATE_EN.
- Read-during-write: LUT[0]=10; write LUT[0]=99 in the same cycle code 0 at c=0 is accepted (C=2, second code reads LUT[16]=1) -> result 11; repeat the row -> 100.
